i2c_reg_writer: RTL
===================

I2C_REG_WRITER -- requirements
Module: i2c_reg_writer

Interface
REQ-001 SHALL have parameter SADR, default 7'b0010000, the 7-bit slave address sent in every transaction.
REQ-002 SHALL have parameter CLK_DIV, default 250, the number of clk cycles per SCL quarter-period; legal range 2..65535.
REQ-003 SHALL have port clk  input  1  system clock; all logic uses its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request pulse; sampled only while idle=1.
REQ-006 SHALL have port address  input  16  target register address; MSB byte is sent first.
REQ-007 SHALL have port data  input  8  register write data.
REQ-008 SHALL have port sda_in  input  1  SDA line level, used for ACK sampling.
REQ-009 SHALL have port ready  output  1  1-cycle pulse confirming that address/data were captured.
REQ-010 SHALL have port idle  output  1  high while the FSM is in IDLE.
REQ-011 SHALL have port done  output  1  1-cycle pulse when a transaction ends, whether it succeeded or aborted.
REQ-012 SHALL have port ack_err  output  1  set when any ACK bit is sampled as 1; held until the next accepted start.
REQ-013 SHALL have port scl  output  1  I2C clock, where 1 means released/high.
REQ-014 SHALL have port sda  output  1  I2C data drive, where 1 means released/high.

Function
REQ-015 SHALL implement an FSM with states IDLE, START, BIT, ACK, STOP and DONE.
REQ-016 SHALL generate a quarter tick every CLK_DIV clk cycles using a counter that is cleared when start is accepted; every phase below lasts exactly 4 quarters.
REQ-017 IDLE: on start=1, SHALL latch the byte sequence {SADR,1'b0}, address[15:8], address[7:0], data; SHALL pulse ready on the next cycle, clear ack_err, and go to START.
REQ-018 start SHALL be ignored outside IDLE; address/data changes after the ready pulse SHALL NOT affect the transaction in progress.
REQ-019 START: quarters 0-1 SHALL drive scl=1, sda=1; quarter 2 SHALL drive scl=1, sda=0; quarter 3 SHALL drive scl=0, sda=0; the FSM then goes to BIT.
REQ-020 BIT: SHALL send MSB first; for each bit, quarter 0 drives scl=0 with sda set to the bit value, quarters 1-2 drive scl=1, quarter 3 drives scl=0; after 8 bits the FSM goes to ACK.
REQ-021 ACK: SHALL use the same scl pattern as BIT with sda=1, and SHALL sample sda_in on the first clk cycle of quarter 2.
REQ-022 If ACK=0 and bytes remain, the FSM SHALL load the next byte and go to BIT; if ACK=0 on the last byte, it SHALL go to STOP.
REQ-023 If ACK=1, the block SHALL set ack_err and go directly to STOP, skipping any remaining bytes.
REQ-024 STOP: quarter 0 SHALL drive scl=0, sda=0; quarter 1 SHALL drive scl=1, sda=0; quarters 2-3 SHALL drive scl=1, sda=1.
REQ-025 DONE: SHALL assert done for exactly 1 cycle, then return to IDLE.
REQ-026 A full acknowledged transaction SHALL take 152 quarters (4 + 4×36 + 4); done SHALL be high exactly 152×CLK_DIV+1 cycles after the cycle in which start was sampled.
REQ-027 A byte counter (2 bits) and a bit counter (3 bits) SHALL reset to 0 at every START.
REQ-028 scl and sda SHALL be registered outputs with no combinational glitches.
REQ-029 scl SHALL change only on quarter boundaries, and sda SHALL change only while scl=0, except for the START and STOP edges.
REQ-030 If start=1 in the same cycle that DONE is active, start SHALL be ignored; start is accepted from the following IDLE cycle.

Reset
REQ-031 While reset=1, the block SHALL immediately force FSM=IDLE, scl=1, sda=1, ready=0, done=0, ack_err=0 and all counters to 0; this holds mid-transaction too, with no STOP generated.
REQ-032 After reset is released, the block SHALL output idle=1 and accept start on the first rising clk edge.

Verification
REQ-033 With CLK_DIV=4, sda_in=0, address=16'h3A5C, data=8'hE7 and a start pulse: the bench SHALL check ready one cycle later, serial bytes 20,3A,5C,E7, 36 scl rising edges, done at cycle 609, and ack_err=0.
REQ-034 With sda_in=1 during the first ACK: the bench SHALL check 9 scl pulses, a STOP, a done pulse, ack_err=1, and that no address or data bits are sent.
REQ-035 Assert reset during the third byte: the bench SHALL check scl=sda=1 and idle=1 in the same cycle; a following start SHALL produce a complete, correct transaction.
REQ-036 Pulse start again while busy and again in the done cycle: the bench SHALL check that both are ignored, with no second ready pulse; a start in the next IDLE cycle SHALL be accepted.
REQ-037 A protocol monitor SHALL check across randomized back-to-back transactions: sda never toggles while scl=1 except at START/STOP, and every START is matched by exactly one STOP.

Source files
------------

// File: rtl/i2c_reg_writer.sv
// Write-only I2C master: sends {SADR,W}, address[15:8], address[7:0], data and
// reports ACK failures. Each bus phase is four quarters of CLK_DIV clk cycles.
//   state | meaning
//   IDLE  | bus released, waiting for start
//   START | start condition (SDA falls while SCL high)
//   BIT   | shifting one data bit, MSB first
//   ACK   | SDA released, slave ACK sampled in quarter 2
//   STOP  | stop condition (SDA rises while SCL high)
//   DONE  | one-cycle done pulse
module i2c_reg_writer #(
  parameter logic [6:0] SADR    = 7'b0010000,
  parameter int         CLK_DIV = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] address,
  input  logic [7:0]  data,
  input  logic        sda_in,
  output logic        ready,
  output logic        idle,
  output logic        done,
  output logic        ack_err,
  output logic        scl,
  output logic        sda
);

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  state_t      state;
  logic [15:0] qdiv;
  logic [1:0]  quarter;
  logic [1:0]  byte_cnt;
  logic [2:0]  bit_cnt;
  logic [31:0] seq;
  logic        ack_bit;
  logic        tick;
  logic        cur_bit;
  logic        nxt_bit;
  logic        nbyte_bit;

  assign tick      = (qdiv == 16'd0);
  assign cur_bit   = seq[5'd31 - {byte_cnt, bit_cnt}];
  assign nxt_bit   = seq[5'd31 - {byte_cnt, bit_cnt + 3'd1}];
  assign nbyte_bit = seq[5'd31 - {byte_cnt + 2'd1, 3'd0}];
  assign idle      = (state == IDLE);

  // {scl, sda} for a given phase and quarter; registered at the quarter boundary.
  function automatic logic [1:0] bus_level(input state_t s, input logic [1:0] q, input logic b);
    case (s)
      START: begin
        case (q)
          2'd0, 2'd1: return 2'b11;
          2'd2:       return 2'b10;
          default:    return 2'b00;
        endcase
      end
      BIT:  return {(q == 2'd1) || (q == 2'd2), b};
      ACK:  return {(q == 2'd1) || (q == 2'd2), 1'b1};
      STOP: begin
        case (q)
          2'd0:    return 2'b00;
          2'd1:    return 2'b10;
          default: return 2'b11;
        endcase
      end
      default: return 2'b11;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      qdiv     <= '0;
      quarter  <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      seq      <= '0;
      ack_bit  <= 1'b0;
      ready    <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      scl      <= 1'b1;
      sda      <= 1'b1;
    end else begin
      ready <= 1'b0;
      done  <= 1'b0;
      if (state != IDLE && state != DONE)
        qdiv <= tick ? DIV_LAST : qdiv - 16'd1;
      case (state)
        IDLE: begin
          if (start) begin
            seq        <= {SADR, 1'b0, address, data};
            ready      <= 1'b1;
            ack_err    <= 1'b0;
            ack_bit    <= 1'b0;
            qdiv       <= DIV_LAST;
            quarter    <= 2'd0;
            byte_cnt   <= 2'd0;
            bit_cnt    <= 3'd0;
            state      <= START;
            {scl, sda} <= bus_level(START, 2'd0, 1'b1);
          end
        end
        START: begin
          if (tick) begin
            quarter <= quarter + 2'd1;
            if (quarter == 2'd3) begin
              state      <= BIT;
              {scl, sda} <= bus_level(BIT, 2'd0, seq[31]);
            end else begin
              {scl, sda} <= bus_level(START, quarter + 2'd1, 1'b1);
            end
          end
        end
        BIT: begin
          if (tick) begin
            quarter <= quarter + 2'd1;
            if (quarter == 2'd3) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state      <= ACK;
                {scl, sda} <= bus_level(ACK, 2'd0, 1'b1);
              end else begin
                {scl, sda} <= bus_level(BIT, 2'd0, nxt_bit);
              end
            end else begin
              {scl, sda} <= bus_level(BIT, quarter + 2'd1, cur_bit);
            end
          end
        end
        ACK: begin
          if (quarter == 2'd2 && qdiv == DIV_LAST) begin
            ack_bit <= sda_in;
            if (sda_in)
              ack_err <= 1'b1;
          end
          if (tick) begin
            quarter <= quarter + 2'd1;
            if (quarter == 2'd3) begin
              if (ack_bit || byte_cnt == 2'd3) begin
                state      <= STOP;
                {scl, sda} <= bus_level(STOP, 2'd0, 1'b1);
              end else begin
                byte_cnt   <= byte_cnt + 2'd1;
                state      <= BIT;
                {scl, sda} <= bus_level(BIT, 2'd0, nbyte_bit);
              end
            end else begin
              {scl, sda} <= bus_level(ACK, quarter + 2'd1, 1'b1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            quarter <= quarter + 2'd1;
            if (quarter == 2'd3) begin
              state      <= DONE;
              done       <= 1'b1;
              {scl, sda} <= 2'b11;
            end else begin
              {scl, sda} <= bus_level(STOP, quarter + 2'd1, 1'b1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
